gmii_tx_arbiter: RTL and testbench

Shares one GMII transmit path between N frame sources (e.g. ARP and UDP generators) in front of the GMII-to-RGMII transmitter. Frames are granted round-robin. Once a frame starts, the grant is held until the source's `tx_en` falls. A programmable inter-frame gap is enforced, and a runaway frame is cut off with `gmii_tx_er`. Everything runs in the `gmii_tx_clk` domain.

---
 rtl/gmii_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/gmii_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_gmii_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_arb_pkg.sv
// Shared types and widths for the GMII transmit arbiter.
package gmii_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XMIT  = 2'd2,
      ST_IFG   = 2'd3
   } arb_state_e;

   localparam int CNT_W  = 16;
   localparam int PORT_W = 3;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping to port 0.
module rr_arbiter
   import gmii_arb_pkg::*;
#(
   parameter int N_PORTS = 2
)(
   input  logic [N_PORTS-1:0] req,
   input  logic [PORT_W-1:0]  ptr,
   output logic               valid,
   output logic [N_PORTS-1:0] gnt,
   output logic [PORT_W-1:0]  idx
);

   logic              hi_found;
   logic [PORT_W-1:0] hi_idx;
   logic [PORT_W-1:0] lo_idx;

   // Descending scan so the last hit written is the lowest index in each class.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int j = N_PORTS - 1; j >= 0; j--) begin
         if (req[j]) begin
            lo_idx = PORT_W'(j);
            if (PORT_W'(j) >= ptr) begin
               hi_found = 1'b1;
               hi_idx   = PORT_W'(j);
            end
         end
      end
      valid = |req;
      idx   = hi_found ? hi_idx : lo_idx;
      gnt   = '0;
      for (int j = 0; j < N_PORTS; j++) begin
         gnt[j] = valid && (idx == PORT_W'(j));
      end
   end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Round-robin sharing of one GMII TX path between N frame sources, with IFG,
// start timeout and oversize cut-off. All outputs are registered.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no grant; pick next requester from the round-robin pointer
//  ST_GRANT | grant held, waiting for the source to raise tx_en
//  ST_XMIT  | forwarding the granted source until tx_en falls or oversize
//  ST_IFG   | forced idle gap before the next arbitration
module gmii_tx_arbiter
   import gmii_arb_pkg::*;
#(
   parameter int N_PORTS          = 2,
   parameter int IFG_CYCLES       = 12,
   parameter int START_TIMEOUT    = 256,
   parameter int MAX_FRAME_CYCLES = 1600
)(
   input  logic                   gmii_tx_clk,
   input  logic                   rst_n,
   input  logic [N_PORTS-1:0]     src_req,
   output logic [N_PORTS-1:0]     src_gnt,
   input  logic [N_PORTS-1:0]     src_tx_en,
   input  logic [N_PORTS-1:0]     src_tx_er,
   input  logic [8*N_PORTS-1:0]   src_txd,
   output logic                   gmii_tx_en,
   output logic                   gmii_tx_er,
   output logic [7:0]             gmii_txd,
   output logic                   busy,
   output logic [PORT_W-1:0]      active_port,
   output logic                   frame_abort
);

   localparam int                IFG_W     = $clog2(IFG_CYCLES + 1);
   localparam logic [CNT_W-1:0]  TMO_LOAD  = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  MAX_BEATS = CNT_W'(MAX_FRAME_CYCLES);
   localparam logic [IFG_W-1:0]  IFG_LOAD  = IFG_W'(IFG_CYCLES - 1);
   localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(N_PORTS - 1);

   arb_state_e          state_q, state_d;
   logic [N_PORTS-1:0]  gnt_q, gnt_d;
   logic [PORT_W-1:0]   ptr_q, ptr_d;
   logic [PORT_W-1:0]   act_q, act_d;
   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [CNT_W-1:0]    tmo_q, tmo_d;
   logic [IFG_W-1:0]    ifg_q, ifg_d;
   logic                tx_en_q, tx_en_d;
   logic                tx_er_q, tx_er_d;
   logic [7:0]          txd_q, txd_d;
   logic                abort_q, abort_d;

   logic                pick_valid;
   logic [N_PORTS-1:0]  pick_gnt;
   logic [PORT_W-1:0]   pick_idx;
   logic                sel_en;
   logic                sel_er;
   logic                sel_req;
   logic [7:0]          sel_txd;
   logic [PORT_W-1:0]   ptr_next;

   rr_arbiter #(
      .N_PORTS (N_PORTS)
   ) u_rr (
      .req   (src_req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .gnt   (pick_gnt),
      .idx   (pick_idx)
   );

   // gnt_q is one-hot while a port owns the path, so it doubles as the mux select.
   assign sel_en   = |(src_tx_en & gnt_q);
   assign sel_er   = |(src_tx_er & gnt_q);
   assign sel_req  = |(src_req & gnt_q);
   assign ptr_next = (act_q == LAST_PORT) ? '0 : act_q + 1'b1;

   always_comb begin
      sel_txd = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (gnt_q[k]) sel_txd = src_txd[8*k +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      act_d   = act_q;
      beat_d  = beat_q;
      tmo_d   = tmo_q;
      ifg_d   = ifg_q;
      tx_en_d = 1'b0;
      tx_er_d = 1'b0;
      txd_d   = '0;
      abort_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick_gnt;
               act_d   = pick_idx;
               tmo_d   = TMO_LOAD;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (sel_en) begin
               tx_en_d = 1'b1;
               tx_er_d = sel_er;
               txd_d   = sel_txd;
               beat_d  = CNT_W'(1);
               ptr_d   = ptr_next;
               state_d = ST_XMIT;
            end else if (!sel_req) begin
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else if (tmo_q == '0) begin
               abort_d = 1'b1;
               gnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               tmo_d = tmo_q - 1'b1;
            end
         end
         ST_XMIT: begin
            tx_er_d = sel_er;
            txd_d   = sel_txd;
            if (!sel_en) begin
               gnt_d   = '0;
               ifg_d   = IFG_LOAD;
               state_d = ST_IFG;
            end else if (beat_q >= MAX_BEATS) begin
               // Runaway frame: emit this beat marked bad, then squash the rest.
               tx_en_d = 1'b1;
               tx_er_d = 1'b1;
               abort_d = 1'b1;
               gnt_d   = '0;
               ifg_d   = IFG_LOAD;
               state_d = ST_IFG;
            end else begin
               tx_en_d = 1'b1;
               beat_d  = sat_inc(beat_q);
            end
         end
         ST_IFG: begin
            if (ifg_q == '0) state_d = ST_IDLE;
            else             ifg_d   = ifg_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         act_q   <= '0;
         beat_q  <= '0;
         tmo_q   <= '0;
         ifg_q   <= '0;
         tx_en_q <= 1'b0;
         tx_er_q <= 1'b0;
         txd_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         act_q   <= act_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         ifg_q   <= ifg_d;
         tx_en_q <= tx_en_d;
         tx_er_q <= tx_er_d;
         txd_q   <= txd_d;
         abort_q <= abort_d;
      end
   end

   assign src_gnt     = gnt_q;
   assign gmii_tx_en  = tx_en_q;
   assign gmii_tx_er  = tx_er_q;
   assign gmii_txd    = txd_q;
   assign busy        = (state_q != ST_IDLE);
   assign active_port = act_q;
   assign frame_abort = abort_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Randomised sources around gmii_tx_arbiter, checked every cycle against a
// timestamp-based reference model of the arbitration rules.
module tb_gmii_tx_arbiter;

   localparam int NP   = 3;
   localparam int IFG  = 12;
   localparam int TMO  = 256;
   localparam int MAXF = 1600;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [NP-1:0]   src_req, src_gnt, src_tx_en, src_tx_er;
   logic [8*NP-1:0] src_txd;
   logic            gmii_tx_en, gmii_tx_er, busy, frame_abort;
   logic [7:0]      gmii_txd;
   logic [2:0]      active_port;

   always #5 clk = ~clk;

   gmii_tx_arbiter #(
      .N_PORTS          (NP),
      .IFG_CYCLES       (IFG),
      .START_TIMEOUT    (TMO),
      .MAX_FRAME_CYCLES (MAXF)
   ) dut (
      .gmii_tx_clk (clk),
      .rst_n       (rst_n),
      .src_req     (src_req),
      .src_gnt     (src_gnt),
      .src_tx_en   (src_tx_en),
      .src_tx_er   (src_tx_er),
      .src_txd     (src_txd),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_tx_er  (gmii_tx_er),
      .gmii_txd    (gmii_txd),
      .busy        (busy),
      .active_port (active_port),
      .frame_abort (frame_abort)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit stop    = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
         if (n_fail >= 50) stop = 1;
      end
   endtask

   // ---------------- reference model ----------------
   // owner < 0 means nobody holds the path; free_at is the first edge at which
   // a new arbitration may happen.
   int         m_owner, m_wait, m_beats, m_free_at, m_ptr, m_last, cyc;
   bit         m_started;
   logic       m_en, m_er, m_abort;
   logic [7:0] m_txd;

   function automatic int pick(input logic [NP-1:0] r, input int ptr);
      for (int i = 0; i < NP; i++)
         if (r[(ptr + i) % NP]) return (ptr + i) % NP;
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_wait = 0; m_beats = 0; m_free_at = 0;
      m_ptr = 0; m_last = 0; cyc = 0; m_started = 0;
      m_en = 0; m_er = 0; m_abort = 0; m_txd = 0;
   endtask

   task automatic model_step();
      m_en = 0; m_er = 0; m_txd = 0; m_abort = 0;
      if (m_owner < 0) begin
         if (cyc >= m_free_at && src_req != '0) begin
            m_owner = pick(src_req, m_ptr);
            m_last = m_owner; m_started = 0; m_wait = 0;
         end
      end else if (!m_started) begin
         if (src_tx_en[m_owner]) begin
            m_started = 1; m_beats = 1;
            m_en = 1; m_er = src_tx_er[m_owner]; m_txd = src_txd[8*m_owner +: 8];
            m_ptr = (m_owner + 1) % NP;
         end else if (!src_req[m_owner]) begin
            m_owner = -1; m_free_at = cyc + 1;
         end else begin
            m_wait++;
            if (m_wait == TMO) begin
               m_abort = 1; m_owner = -1; m_free_at = cyc + 1;
            end
         end
      end else begin
         if (!src_tx_en[m_owner]) begin
            m_owner = -1; m_free_at = cyc + 1 + IFG;
         end else if (m_beats == MAXF) begin
            m_en = 1; m_er = 1; m_txd = src_txd[8*m_owner +: 8];
            m_abort = 1; m_owner = -1; m_free_at = cyc + 1 + IFG;
         end else begin
            m_beats++;
            m_en = 1; m_er = src_tx_er[m_owner]; m_txd = src_txd[8*m_owner +: 8];
         end
      end
      cyc++;
   endtask

   task automatic compare();
      logic [NP-1:0] exp_gnt;
      exp_gnt = (m_owner >= 0) ? (NP'(1) << m_owner) : '0;
      check_eq("src_gnt", src_gnt, exp_gnt);
      check_eq("gmii_tx_en", gmii_tx_en, m_en);
      if (m_en) begin
         check_eq("gmii_tx_er", gmii_tx_er, m_er);
         check_eq("gmii_txd", gmii_txd, m_txd);
      end
      check_eq("frame_abort", frame_abort, m_abort);
      check_eq("busy", busy, (m_owner >= 0) || (cyc < m_free_at));
      check_eq("active_port", active_port, m_last);
   endtask

   // ---------------- frame sources ----------------
   // ph: 0 off, 1 requesting, 2 sending. kind: 0 normal, 1 never starts, 2 may withdraw.
   int ph[NP], len[NP], sent[NP], dly[NP], kind[NP], rep_len[NP];
   bit seen_g[NP], keep_req[NP];
   bit auto_en = 0, rogue_en = 0;

   task automatic start_frame(input int p, input int l, input int k, input bit keep);
      ph[p] = 1; len[p] = l; kind[p] = k; keep_req[p] = keep;
      dly[p] = 0; seen_g[p] = 0; src_req[p] = 1'b1; src_tx_en[p] = 1'b0;
   endtask

   task automatic clear_sources();
      for (int p = 0; p < NP; p++) begin
         ph[p] = 0; rep_len[p] = 0; sent[p] = 0; kind[p] = 0;
      end
      src_req = '0; src_tx_en = '0; src_tx_er = '0; src_txd = '0;
   endtask

   task automatic drive_sources();
      for (int p = 0; p < NP; p++) begin
         logic g;
         g = src_gnt[p];
         src_tx_er[p] = 1'b0;
         case (ph[p])
            0: begin
               src_req[p]       = 1'b0;
               src_tx_en[p]     = rogue_en && ($urandom_range(0, 4) == 0);
               src_txd[8*p +: 8] = 8'($urandom);
               if (rep_len[p] > 0) begin
                  start_frame(p, rep_len[p], 0, 1);
               end else if (auto_en && $urandom_range(0, 5) == 0) begin
                  start_frame(p, $urandom_range(1, 40), ($urandom_range(0, 9) == 0) ? 2 : 0,
                              1'($urandom_range(0, 1)));
                  dly[p] = $urandom_range(0, 2);
               end
            end
            1: begin
               if (kind[p] == 1) begin
                  src_tx_en[p] = 1'b0;
                  if (g) seen_g[p] = 1;
                  else if (seen_g[p]) begin
                     kind[p] = 0; len[p] = 10;
                  end
               end else if (kind[p] == 2 && $urandom_range(0, 3) == 0) begin
                  src_req[p] = 1'b0; src_tx_en[p] = 1'b0; ph[p] = 0;
               end else if (!g) begin
                  src_tx_en[p]      = rogue_en && ($urandom_range(0, 4) == 0);
                  src_txd[8*p +: 8] = 8'($urandom);
               end else if (dly[p] > 0) begin
                  dly[p]--; src_tx_en[p] = 1'b0;
               end else begin
                  src_tx_en[p]      = 1'b1;
                  src_tx_er[p]      = ($urandom_range(0, 15) == 0);
                  src_txd[8*p +: 8] = 8'($urandom);
                  sent[p] = 1; ph[p] = 2;
                  if (!keep_req[p]) src_req[p] = 1'b0;
               end
            end
            default: begin
               if (sent[p] < len[p]) begin
                  src_tx_en[p]      = 1'b1;
                  src_tx_er[p]      = ($urandom_range(0, 15) == 0);
                  src_txd[8*p +: 8] = 8'($urandom);
                  sent[p]++;
               end else begin
                  src_tx_en[p] = 1'b0; src_req[p] = 1'b0; ph[p] = 0;
               end
            end
         endcase
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n && !stop; i++) begin
         @(posedge clk); #1;
         model_step();
         compare();
         drive_sources();
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_gnt"}, src_gnt, '0);
      check_eq({tag, "_tx_en"}, gmii_tx_en, 1'b0);
      check_eq({tag, "_tx_er"}, gmii_tx_er, 1'b0);
      check_eq({tag, "_txd"}, gmii_txd, 8'h00);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_active_port"}, active_port, 3'd0);
      check_eq({tag, "_abort"}, frame_abort, 1'b0);
   endtask

   initial begin
      bit reached;
      clear_sources();
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;

      // single source, 72-beat frame; leaves pointer at port 1
      start_frame(0, 72, 0, 1);
      run_cycles(100);

      // port 1 never starts; port 0 waits; port 1 retries and must win again
      start_frame(1, 0, 1, 1);
      run_cycles(5);
      start_frame(0, 20, 0, 1);
      run_cycles(330);

      // contention with rogue tx_en on waiting/idle ports
      rogue_en = 1;
      rep_len[0] = 60; rep_len[1] = 60;
      run_cycles(400);
      rep_len[0] = 0; rep_len[1] = 0;
      run_cycles(150);
      rogue_en = 0;

      // oversize: request dropped at start, tx_en held for 1700 beats
      start_frame(0, 1700, 0, 0);
      run_cycles(1760);

      // randomised traffic
      auto_en = 1; rogue_en = 1;
      run_cycles(3000);
      auto_en = 0; rogue_en = 0;
      run_cycles(200);

      // async reset in the middle of a frame
      start_frame(0, 60, 0, 1);
      reached = 0;
      for (int i = 0; i < 200 && !reached && !stop; i++) begin
         run_cycles(1);
         if (m_owner == 0 && m_started && m_beats >= 30) reached = 1;
      end
      check_eq("beat30_reached", reached, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midframe_reset");
      clear_sources();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      start_frame(1, 15, 0, 1);
      start_frame(0, 15, 0, 1);
      run_cycles(120);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
